uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one uart_tx instance among four byte sources, e.g. loopback path, status reporter, debug dump and command responder.
- uart_tx gives no busy or done indication. The arbiter times each frame itself from clk_frequence and baud_rate.
- After the frame time it issues the next single-cycle pi_data/pi_flag launch.
- Sits between the requesters and uart_tx; its pi_data and pi_flag outputs connect directly to uart_tx.

Parameters:
- clk_frequence, 5_000_000, system clock in Hz.
- baud_rate, 9600, line rate in baud.
- FRAME_BITS, 10, bits per frame: start + 8 data + stop.
- GUARD_CYCLES, 2, extra idle clocks after each frame before the next launch.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-requester level request; bit i belongs to requester i.
- req_data  input  32  requester i byte on [8i+7:8i]; must be valid while req[i]=1.
- grant  output  4  one-hot, one-cycle acknowledge; the byte has been taken.
- pi_data  output  8  byte to uart_tx.
- pi_flag  output  1  one-cycle launch strobe to uart_tx.
- busy  output  1  high while a frame is in flight, including the guard time.

Behaviour:
- Derived constants (integer division):
  - BIT_CYCLES = clk_frequence/baud_rate, 520 at defaults.
  - FRAME_CYCLES = BIT_CYCLES*FRAME_BITS, 5200.
  - HOLD = FRAME_CYCLES+GUARD_CYCLES, 5202.
  - Counter width is $clog2(HOLD).
- Reset (rst sampled high at a clk edge):
  - grant=0, pi_data=0, pi_flag=0, busy=0.
  - State=IDLE, counter=0, last-grant pointer=3, so requester 0 has first priority.
- Reset wins over every other event, including mid-WAIT. The in-flight uart_tx frame is not tracked after reset.
- States are IDLE and WAIT.
- IDLE:
  - If req==0, stay in IDLE; all outputs stay 0.
  - Otherwise, in cycle T, select winner w: the first set bit scanning last+1, last+2, last+3, last (mod 4).
  - Latch pi_data=req_data[8w+7:8w] and set last=w.
  - Go to WAIT with counter=0.
- Registered outputs in cycle T+1:
  - grant[w]=1, pi_flag=1, busy=1, pi_data=byte.
  - grant and pi_flag return to 0 at T+2.
  - pi_data holds until the next launch.
- WAIT:
  - busy=1; counter increments every cycle starting at T+1.
  - When counter==HOLD-1, busy=0 on the next cycle and the state returns to IDLE.
  - busy is high for exactly HOLD cycles (T+1 .. T+HOLD). State is IDLE from T+HOLD+1.
  - The earliest next pi_flag is at T+HOLD+2. Minimum launch-to-launch spacing is HOLD+1 = 5203 cycles.
- req is ignored in WAIT. Requests arriving during busy are held by the requester and arbitrated in the first IDLE cycle.
- Requester protocol:
  - Hold req[i] and its byte stable until grant[i] is seen.
  - May deassert req, or present a new byte, from the cycle after grant.
  - Keeping req high through the grant cycle is legal and does not cause a double grant.
- A req dropped before being sampled in IDLE is simply never granted; there is no stored request state.
- At most one grant bit is ever high. grant and pi_flag are always coincident.
- Fairness: each requester with continuous req is granted at least once per 4 launches.

Test Plan:
- Idle after reset: req=0 for 20000 cycles -> pi_flag, grant and busy stay 0, pi_data=0.
- Single request: req=4'b0010, byte1=8'hA5 at cycle T -> at T+1, grant=4'b0010, pi_flag=1, pi_data=8'hA5. busy high for exactly 5202 cycles. uart_tx line shows 0xA5 at 9600 baud.
- All four requesting continuously with bytes 11/22/33/44 from reset -> grants in order 0,1,2,3,0, spaced exactly 5203 cycles. pi_data follows 11,22,33,44,11.
- Request during busy: req0 is granted, then req2 asserts at grant+100 -> no grant until the first IDLE cycle. grant=4'b0100 lands exactly 5203 cycles after the req0 grant.
- Fairness with priority pointer: req0 and req2 both held high -> grants alternate 0,2,0,2. Requesters 1 and 3 are never granted.
- Reset mid-WAIT: rst at launch+1000 -> next cycle busy=0, outputs 0, pointer=3. With req=4'b1001 after reset, requester 0 is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bus between the four byte requesters, the arbiter and the shared uart_tx.
// The master side belongs to the requesters and observers.
// The slave side belongs to the arbiter.
interface uart_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [7:0]  pi_data;
  logic        pi_flag;
  logic        busy;

  modport master (
    output req,
    output req_data,
    input  grant,
    input  pi_data,
    input  pi_flag,
    input  busy
  );

  modport slave (
    input  req,
    input  req_data,
    output grant,
    output pi_data,
    output pi_flag,
    output busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one uart_tx among four byte sources.
// uart_tx reports neither busy nor done, so the arbiter times each frame
// itself. A frame lasts one frame time plus a few guard clocks.
module uart_tx_arbiter #(
  parameter int clk_frequence = 5_000_000,
  parameter int baud_rate     = 9600,
  parameter int FRAME_BITS    = 10,
  parameter int GUARD_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int BIT_CYCLES   = clk_frequence / baud_rate;
  localparam int FRAME_CYCLES = BIT_CYCLES * FRAME_BITS;
  localparam int HOLD         = FRAME_CYCLES + GUARD_CYCLES;
  localparam int CW           = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(HOLD - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] counter;
  logic [1:0]    last;
  logic [1:0]    winner;
  logic [1:0]    scan_idx;
  logic          found;
  logic          launch;
  logic          frame_done;

  logic [3:0]    grant_q;
  logic [7:0]    pi_data_q;
  logic          pi_flag_q;
  logic          busy_q;

  logic [3:0]    grant_next;
  logic [7:0]    pi_data_next;
  logic          pi_flag_next;
  logic          busy_next;

  assign frame_done  = (state == ST_WAIT) && (counter == LAST_COUNT);
  assign launch      = (state == ST_IDLE) && (|bus.req);

  assign bus.grant   = grant_q;
  assign bus.pi_data = pi_data_q;
  assign bus.pi_flag = pi_flag_q;
  assign bus.busy    = busy_q;

  // Pick the first requester after the last winner, wrapping round to it last.
  always_comb begin
    winner   = last;
    found    = 1'b0;
    scan_idx = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last + 2'(k);
      if (!found && bus.req[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  // Reset wins over everything. The frame counter runs only while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      counter <= '0;
      last    <= 2'd3;
    end else begin
      state <= next_state;
      if (launch) begin
        counter <= '0;
        last    <= winner;
      end else if (state == ST_WAIT && !frame_done) begin
        counter <= counter + 1'b1;
      end else begin
        counter <= '0;
      end
    end
  end

  // Leave idle on any request; return once the frame and guard time have elapsed.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (|bus.req)  next_state = ST_WAIT;
      ST_WAIT: if (frame_done) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs. pi_data keeps the last launched byte.
  always_comb begin
    grant_next   = 4'b0000;
    pi_flag_next = launch;
    busy_next    = launch || (state == ST_WAIT && !frame_done);
    pi_data_next = pi_data_q;
    if (launch) begin
      grant_next[winner] = 1'b1;
      pi_data_next       = bus.req_data[{winner, 3'b000} +: 8];
    end
  end

  // Outputs are registered so that grant and pi_flag stay coincident and glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q   <= 4'b0000;
      pi_data_q <= 8'h00;
      pi_flag_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      grant_q   <= grant_next;
      pi_data_q <= pi_data_next;
      pi_flag_q <= pi_flag_next;
      busy_q    <= busy_next;
    end
  end

endmodule
